pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined logarithmic barrel shifter. Generalises the single fixed-distance, left-only shift level to any power-of-two width.
- Supports SLL, SRL and SRA, with ROL as an option. A shift-amount bit k selects a 2^k shift at level k.
- One register per level; valid/ready handshake with backpressure. Sits in the EX stage as the multi-cycle shift unit feeding the EX/MEM result mux.

Parameters:
- WIDTH, 32, data width; power of two, 4 to 64.
- SHAMT_W, $clog2(WIDTH), shift-amount width; equals the number of levels and the latency.
- TAG_W, 5, sideband tag width (destination register number), carried through unchanged.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  shifter can accept a beat this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount
- in_op  in  2  operation (see package)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result
- out_zero  out  1  out_data == 0

Behaviour:
- Reset:
  - Synchronous and active-high; clk is the only clock.
  - On rst: every stage valid bit, out_valid and out_zero go to 0; out_data and out_tag go to 0.
  - Reset mid-operation discards all in-flight beats. in_ready is 1 in the first cycle after reset.
- Structure:
  - SHAMT_W levels. Level k takes the previous level's value, shifts it by 2^k when the carried shamt[k] is 1, and registers the result.
  - Each stage register holds {valid, data, shamt, op, tag}.
- Shift rules per level:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original operand MSB. The sign bit is carried down the pipe, so it is not re-read from partial data.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Latency: exactly SHAMT_W cycles from an accepted beat (in_valid && in_ready at edge N) to out_valid at edge N+SHAMT_W, with no stalls. Throughput is 1 beat per cycle.
- Shift amounts:
  - shamt 0 gives out_data == in_data for every op.
  - Maximum shamt WIDTH-1 is legal. Shifts of WIDTH or more are impossible by construction.
- Handshake:
  - advance = !out_valid || out_ready. in_ready = advance, a combinational path from out_ready.
  - When advance is 0, all stages hold; there is no bubble collapsing.
  - When advance is 1, stage 0 loads in_valid and each later stage loads its predecessor, including valid = 0 bubbles.
- Boundary cases:
  - in_valid held while in_ready is 0: the beat is not taken. The source keeps in_data, in_shamt, in_op and in_tag stable.
  - out_valid && !out_ready: out_data, out_tag and out_zero hold stable.
  - Pipe full and out_ready rising: the result leaves and a new beat enters in the same cycle.
- out_zero is registered together with the final stage.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: op 2'b11 performs ROL as described above.
- Undefined: op 2'b11 decodes as SLL and the rotate wrap logic is not built.

Decomposition:
- Package shifter_pkg holds:
  - op typedef shift_op_e with OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11;
  - the stage-payload struct typedef, parametrised by width through the localparams in the module.
- One sub-module, shift_level:
  - purely combinational;
  - parameters WIDTH and DIST;
  - inputs data, enable, op, sign; output shifted data.
- The top module generates SHAMT_W instances of shift_level and owns the stage registers and the handshake.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid=1, then release -> out_valid stays 0 for SHAMT_W cycles after release; in_ready=1.
- Basic ops, WIDTH=32, one beat each with out_ready=1:
  - SLL 0x0000_0001 by 31 -> 0x8000_0000;
  - SRL 0x8000_0000 by 31 -> 0x0000_0001;
  - SRA 0x8000_0000 by 4 -> 0xF800_0000;
  - each arrives exactly 5 cycles after acceptance, with the tag preserved.
- Zero flag: SLL 0x8000_0000 by 1 -> out_data=0, out_zero=1. Shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF, out_zero=0.
- Backpressure: stream 8 beats back-to-back with out_ready=0 from cycle 3 to cycle 10 -> in_ready falls once the pipe is full; no beat is lost, duplicated or reordered; out_data is stable while stalled.
- Reset mid-operation: accept 3 beats, assert rst for 1 cycle -> no out_valid pulses from those 3 beats ever appear.
- Rotate (with SHIFTER_ROTATE_EN): ROL 0x8000_0001 by 1 -> 0x0000_0003. Without the macro, the same stimulus -> 0x0000_0002.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined barrel shifter:
//   - shift_op_e : operation encoding carried alongside each beat
//   - decode_op  : maps the raw 2-bit op field onto shift_op_e
// Build option:
//   SHIFTER_ROTATE_EN - when defined, op 2'b11 performs rotate-left (ROL).
//                       When undefined, op 2'b11 decodes as SLL and no
//                       rotate wrap logic is generated in the levels.
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_e;

    // Decode once at the pipe entry so every level sees an op it can act on.
    // Without rotate support, 2'b11 collapses to SLL here, so no level ever
    // receives OP_ROL.
    function automatic shift_op_e decode_op(input logic [1:0] raw);
        shift_op_e op;
        case (raw)
            2'b00:   op = OP_SLL;
            2'b01:   op = OP_SRL;
            2'b10:   op = OP_SRA;
`ifdef SHIFTER_ROTATE_EN
            2'b11:   op = OP_ROL;
`else
            2'b11:   op = OP_SLL;
`endif
            default: op = OP_SLL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One purely combinational level of the logarithmic barrel shifter. When
// enable is set, the input word is moved by the fixed distance DIST in the
// direction selected by op; otherwise it passes through unchanged.
// Parameters:
//   WIDTH - data width
//   DIST  - fixed shift distance of this level (a power of two, < WIDTH)
// Ports:
//   data    in  WIDTH  partially shifted word from the previous level
//   enable  in  1      shift-amount bit belonging to this level
//   op      in  2      decoded operation (shift_op_e)
//   sign    in  1      MSB of the original operand, used as SRA fill
//   shifted out WIDTH  result of this level
// Build option:
//   SHIFTER_ROTATE_EN - adds the ROL wrap path.
// -----------------------------------------------------------------------------
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  shift_op_e        op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);

    // Fixed-distance shift selected by op; pass-through when not enabled.
    always_comb begin
        shifted = data;
        if (enable) begin
            case (op)
                OP_SLL:  shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                OP_SRL:  shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                // The fill comes from the original operand's sign bit, not from
                // the partial data, which earlier levels may already have moved.
                OP_SRA:  shifted = {{DIST{sign}}, data[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
                OP_ROL:  shifted = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
`endif
                default: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            endcase
        end else begin
            shifted = data;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Fully pipelined logarithmic barrel shifter for the EX-stage shift unit.
// Level k shifts by 2^k when the carried shamt[k] is set, and every level is
// followed by one register, so latency is SHAMT_W cycles at one beat/cycle.
// The whole pipe advances together under a single valid/ready handshake;
// when the output is stalled every stage holds (no bubble collapsing).
// Parameters:
//   WIDTH   - data width, power of two in 4..64
//   SHAMT_W - shift-amount width = number of levels = latency
//   TAG_W   - sideband tag width, carried through unchanged
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous active-high reset
//   in_valid   in  1        input beat valid
//   in_ready   out 1        beat can be accepted (combinational from out_ready)
//   in_data    in  WIDTH    operand
//   in_shamt   in  SHAMT_W  shift amount
//   in_op      in  2        operation (shifter_pkg::shift_op_e encoding)
//   in_tag     in  TAG_W    sideband tag
//   out_valid  out 1        result valid
//   out_ready  in  1        consumer accepts the result
//   out_data   out WIDTH    shifted result
//   out_tag    out TAG_W    tag of the result
//   out_zero   out 1        out_data == 0 (registered with the result)
// Build option:
//   SHIFTER_ROTATE_EN - op 2'b11 performs ROL; otherwise it behaves as SLL.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    // Stage payload. sign is the original operand MSB, carried so SRA fill
    // never depends on partially shifted data.
    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        shift_op_e          op;
        logic               sign;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    // The last level's register is the output register itself, so only
    // SHAMT_W-1 interior payload registers are needed.
    localparam int NREG = SHAMT_W - 1;

    stage_t           lvl_in_s  [SHAMT_W];
    stage_t           lvl_out_s [SHAMT_W];
    logic [WIDTH-1:0] shifted_s [SHAMT_W];
    stage_t           stage_r   [NREG];

    logic             advance_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             out_zero_r;

    // Pipe moves whenever the output slot is empty or being drained.
    always_comb begin
        advance_s = !out_valid_r || out_ready;
    end

    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;
    assign out_zero  = out_zero_r;

    // Level inputs: level 0 sees the incoming beat, level k the register of level k-1.
    always_comb begin
        lvl_in_s[0].valid = in_valid;
        lvl_in_s[0].data  = in_data;
        lvl_in_s[0].shamt = in_shamt;
        lvl_in_s[0].op    = decode_op(in_op);
        lvl_in_s[0].sign  = in_data[WIDTH-1];
        lvl_in_s[0].tag   = in_tag;
        for (int k = 1; k < SHAMT_W; k++) begin
            lvl_in_s[k] = stage_r[k-1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .data    (lvl_in_s[k].data),
            .enable  (lvl_in_s[k].shamt[k]),
            .op      (lvl_in_s[k].op),
            .sign    (lvl_in_s[k].sign),
            .shifted (shifted_s[k])
        );
    end

    // Level outputs: payload passes through, only the data word is replaced.
    always_comb begin
        for (int k = 0; k < SHAMT_W; k++) begin
            lvl_out_s[k]      = lvl_in_s[k];
            lvl_out_s[k].data = shifted_s[k];
        end
    end

    // Stage and output registers; reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                stage_r[k] <= '0;
            end
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_tag_r   <= '0;
            out_zero_r  <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < NREG; k++) begin
                stage_r[k] <= lvl_out_s[k];
            end
            out_valid_r <= lvl_out_s[SHAMT_W-1].valid;
            out_data_r  <= lvl_out_s[SHAMT_W-1].data;
            out_tag_r   <= lvl_out_s[SHAMT_W-1].tag;
            // Only a real result can raise the zero flag.
            out_zero_r  <= lvl_out_s[SHAMT_W-1].valid &&
                           (lvl_out_s[SHAMT_W-1].data == {WIDTH{1'b0}});
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=32).
// Expected values are hand-computed constants. SHIFTER_ROTATE_EN selects the
// expected rotate result.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one beat with out_ready=1 and check latency, data, tag and zero flag.
    task automatic one_beat(input string tag, input logic [1:0] op, input logic [31:0] d,
                            input logic [4:0] sh, input logic [4:0] tg,
                            input logic [31:0] exp_d, input logic exp_z);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(SHAMT_W));
        chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
        chk({tag, "_tag"}, 64'(out_tag), 64'(tg));
        chk({tag, "_zero"}, 64'(out_zero), 64'(exp_z));
    endtask

    logic [1:0]  bp_op [8];
    logic [31:0] bp_d  [8];
    logic [4:0]  bp_sh [8];
    logic [31:0] bp_e  [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rol_exp;
        int sent;
        int recv;
        int extra;
        int pulses;
        bit saw_stall;

        // ---------------- reset with in_valid held high ----------------
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1111_1111;
        in_shamt  = 5'd0;
        in_op     = SLL;
        in_tag    = 5'd9;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < SHAMT_W; i++) begin
            @(negedge clk);
            chk($sformatf("rst_idle_valid%0d", i), 64'(out_valid), 64'd0);
        end

        // ---------------- basic ops ----------------
        one_beat("sll31", SLL, 32'h0000_0001, 5'd31, 5'd3,  32'h8000_0000, 1'b0);
        one_beat("srl31", SRL, 32'h8000_0000, 5'd31, 5'd7,  32'h0000_0001, 1'b0);
        one_beat("sra4",  SRA, 32'h8000_0000, 5'd4,  5'd12, 32'hF800_0000, 1'b0);
        one_beat("sra_pos", SRA, 32'h7000_0000, 5'd4, 5'd13, 32'h0700_0000, 1'b0);
        one_beat("zero",  SLL, 32'h8000_0000, 5'd1,  5'd17, 32'h0000_0000, 1'b1);
        one_beat("sh0",   SRA, 32'hDEAD_BEEF, 5'd0,  5'd30, 32'hDEAD_BEEF, 1'b0);

`ifdef SHIFTER_ROTATE_EN
        rol_exp = 32'h0000_0003;
`else
        rol_exp = 32'h0000_0002;
`endif
        one_beat("rol1", ROL, 32'h8000_0001, 5'd1, 5'd21, rol_exp, 1'b0);

        // ---------------- backpressure stream ----------------
        bp_op[0] = SLL; bp_d[0] = 32'h0000_00FF; bp_sh[0] = 5'd8;  bp_e[0] = 32'h0000_FF00;
        bp_op[1] = SRL; bp_d[1] = 32'hF000_0000; bp_sh[1] = 5'd28; bp_e[1] = 32'h0000_000F;
        bp_op[2] = SRA; bp_d[2] = 32'hF000_0000; bp_sh[2] = 5'd28; bp_e[2] = 32'hFFFF_FFFF;
        bp_op[3] = SLL; bp_d[3] = 32'h1234_5678; bp_sh[3] = 5'd4;  bp_e[3] = 32'h2345_6780;
        bp_op[4] = SRL; bp_d[4] = 32'h1234_5678; bp_sh[4] = 5'd16; bp_e[4] = 32'h0000_1234;
        bp_op[5] = SRA; bp_d[5] = 32'h8765_4321; bp_sh[5] = 5'd8;  bp_e[5] = 32'hFF87_6543;
        bp_op[6] = SLL; bp_d[6] = 32'h0000_0003; bp_sh[6] = 5'd30; bp_e[6] = 32'hC000_0000;
        bp_op[7] = SRA; bp_d[7] = 32'h4000_0000; bp_sh[7] = 5'd30; bp_e[7] = 32'h0000_0001;

        sent      = 0;
        recv      = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 10);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_op    = bp_op[sent];
                in_data  = bp_d[sent];
                in_shamt = bp_sh[sent];
                in_tag   = 5'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            // Every cycle the output is valid, including stalled ones, it must
            // show the oldest outstanding beat.
            if (out_valid) begin
                chk($sformatf("bp_data_b%0d_c%0d", recv, c), 64'(out_data), 64'(bp_e[recv]));
                chk($sformatf("bp_tag_b%0d_c%0d", recv, c), 64'(out_tag), 64'(recv + 1));
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) recv++;
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_recv_count", 64'(recv), 64'd8);
        chk("bp_saw_stall", 64'(saw_stall), 64'd1);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_no_duplicates", 64'(extra), 64'd0);

        // ---------------- reset mid-operation ----------------
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = SLL;
            in_data  = 32'h0000_0010 + 32'(i);
            in_shamt = 5'd1;
            in_tag   = 5'(20 + i);
            #1;
            chk($sformatf("mid_in_ready%0d", i), 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        if (out_valid) pulses++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("mid_rst_pulses", 64'(pulses), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
